// File: rtl/lfsr_keystream_gen.sv
// Fibonacci LFSR keystream generator.
// Serialises OUT_W LFSR output bits into keystream words and hands them to
// the cipher XOR stage over a valid/ready handshake. The LFSR stalls while a
// finished word waits, so no keystream bit is lost or skipped. Runtime seed
// loading substitutes DEFAULT_SEED for an all-zero seed, which keeps the
// LFSR out of its lock-up state.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_FILL  | stepping the LFSR (when enable=1) and assembling a word
// ST_VALID | word complete on ks_data, LFSR frozen until ks_ready
module lfsr_keystream_gen #(
   parameter int                 WIDTH        = 32,
   parameter logic [WIDTH-1:0]   TAPS         = 32'h80200003,
   parameter int                 OUT_W        = 32,
   parameter logic [WIDTH-1:0]   DEFAULT_SEED = 32'h00000001
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              seed_load,
   input  logic [WIDTH-1:0]  seed,
   input  logic              ks_ready,
   output logic              ks_valid,
   output logic [OUT_W-1:0]  ks_data,
   output logic              seed_zero,
   output logic              busy
);

   localparam int                CNT_W = $clog2(OUT_W + 1);
   localparam logic [CNT_W-1:0]  LAST  = CNT_W'(OUT_W - 1);

   typedef enum logic [0:0] {
      ST_FILL  = 1'b0,
      ST_VALID = 1'b1
   } state_t;

   state_t              state, state_nxt;
   logic [WIDTH-1:0]    lfsr, lfsr_nxt;
   logic [OUT_W-1:0]    acc, acc_nxt;
   logic [CNT_W-1:0]    count, count_nxt;
   logic                ks_valid_nxt;
   logic [OUT_W-1:0]    ks_data_nxt;
   logic                seed_zero_nxt;

   logic                out_bit;
   logic                fb;
   logic                seed_is_zero;
   logic [WIDTH-1:0]    lfsr_shift;
   logic [OUT_W-1:0]    acc_shift;

   assign out_bit      = lfsr[WIDTH-1];
   assign fb           = ^(lfsr & TAPS);
   assign lfsr_shift   = {lfsr[WIDTH-2:0], fb};
   assign seed_is_zero = (seed == '0);

   // First generated bit of a word ends up in the MSB; a 1-bit word has no
   // upper slice to shift, so it is just the current output bit.
   generate
      if (OUT_W == 1) begin : g_acc_1
         assign acc_shift = out_bit;
      end else begin : g_acc_n
         assign acc_shift = {acc[OUT_W-2:0], out_bit};
      end
   endgenerate

   // Next-state and datapath update; seed_load beats any state activity.
   always_comb begin
      state_nxt     = state;
      lfsr_nxt      = lfsr;
      acc_nxt       = acc;
      count_nxt     = count;
      ks_valid_nxt  = ks_valid;
      ks_data_nxt   = ks_data;
      seed_zero_nxt = 1'b0;

      if (seed_load) begin
         // A pending word is dropped; if ks_ready was high it was taken this edge.
         lfsr_nxt      = seed_is_zero ? DEFAULT_SEED : seed;
         acc_nxt       = '0;
         count_nxt     = '0;
         ks_valid_nxt  = 1'b0;
         seed_zero_nxt = seed_is_zero;
         state_nxt     = ST_FILL;
      end else begin
         case (state)
            ST_FILL: begin
               if (enable) begin
                  lfsr_nxt = lfsr_shift;
                  if (count == LAST) begin
                     ks_data_nxt  = acc_shift;
                     ks_valid_nxt = 1'b1;
                     acc_nxt      = '0;
                     count_nxt    = '0;
                     state_nxt    = ST_VALID;
                  end else begin
                     acc_nxt   = acc_shift;
                     count_nxt = count + 1'b1;
                  end
               end
            end
            ST_VALID: begin
               if (ks_ready) begin
                  ks_valid_nxt = 1'b0;
                  state_nxt    = ST_FILL;
               end
            end
            default: begin
               state_nxt = ST_FILL;
            end
         endcase
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_FILL;
         lfsr      <= DEFAULT_SEED;
         acc       <= '0;
         count     <= '0;
         ks_valid  <= 1'b0;
         ks_data   <= '0;
         seed_zero <= 1'b0;
      end else begin
         state     <= state_nxt;
         lfsr      <= lfsr_nxt;
         acc       <= acc_nxt;
         count     <= count_nxt;
         ks_valid  <= ks_valid_nxt;
         ks_data   <= ks_data_nxt;
         seed_zero <= seed_zero_nxt;
      end
   end

   assign busy = (state == ST_FILL);

endmodule

// File: tb/tb_lfsr_keystream_gen.sv
// Directed bench for lfsr_keystream_gen in an 8-bit configuration
// (taps 8'hB8, 8-bit words, default seed 8'h01). Expected words were worked
// out by hand from the LFSR recurrence: 8'h01, 8'h1C, 8'h4B, ...
module tb_lfsr_keystream_gen;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic        seed_load;
   logic [7:0]  seed;
   logic        ks_ready;
   logic        ks_valid;
   logic [7:0]  ks_data;
   logic        seed_zero;
   logic        busy;

   int n_checks = 0;
   int n_pass   = 0;

   lfsr_keystream_gen #(
      .WIDTH        (8),
      .TAPS         (8'hB8),
      .OUT_W        (8),
      .DEFAULT_SEED (8'h01)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .seed_load (seed_load),
      .seed      (seed),
      .ks_ready  (ks_ready),
      .ks_valid  (ks_valid),
      .ks_data   (ks_data),
      .seed_zero (seed_zero),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Compare one observed value against its expected value.
   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Advance edges until ks_valid is seen (at least one edge, bounded).
   task automatic next_word(output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (!ks_valid && n < 100);
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      seed_load = 1'b0;
      step();
      reset     = 1'b0;
   endtask

   int          n;
   int          ph;
   int          rep;
   logic [7:0]  words [256];

   initial begin
      reset     = 1'b1;
      enable    = 1'b0;
      seed_load = 1'b0;
      seed      = 8'h00;
      ks_ready  = 1'b0;

      // Reset values and first words
      step();
      step();
      check_val("rst_valid", ks_valid, 0);
      check_val("rst_data", ks_data, 0);
      check_val("rst_busy", busy, 1);
      check_val("rst_seed_zero", seed_zero, 0);
      enable   = 1'b1;
      ks_ready = 1'b1;
      do_reset();
      next_word(n);
      check_val("t1_latency", n, 8);
      check_val("t1_word0", ks_data, 8'h01);
      check_val("t1_busy_valid", busy, 0);
      next_word(n);
      check_val("t1_gap", n, 9);
      check_val("t1_word1", ks_data, 8'h1C);

      // Back-pressure: word holds while ks_ready is low
      ks_ready = 1'b0;
      do_reset();
      next_word(n);
      check_val("t4_word0", ks_data, 8'h01);
      for (int i = 0; i < 20; i++) begin
         step();
         check_val("t4_stall_data", ks_data, 8'h01);
         check_val("t4_stall_valid", ks_valid, 1);
      end
      ks_ready = 1'b1;
      next_word(n);
      check_val("t4_gap", n, 9);
      check_val("t4_word1", ks_data, 8'h1C);

      // Seed load mid-fill discards the partial word
      do_reset();
      step(); step(); step();
      check_val("t2_pre_valid", ks_valid, 0);
      seed_load = 1'b1;
      seed      = 8'hA5;
      step();
      seed_load = 1'b0;
      check_val("t2_valid", ks_valid, 0);
      check_val("t2_seed_zero", seed_zero, 0);
      check_val("t2_busy", busy, 1);
      next_word(n);
      check_val("t2_latency", n, 8);
      check_val("t2_word", ks_data, 8'hA5);
      check_val("t2_seed_zero_end", seed_zero, 0);

      // Zero seed falls back to the default seed
      seed_load = 1'b1;
      seed      = 8'h00;
      step();
      seed_load = 1'b0;
      check_val("t3_seed_zero_pulse", seed_zero, 1);
      check_val("t3_valid", ks_valid, 0);
      step();
      check_val("t3_seed_zero_drop", seed_zero, 0);
      next_word(n);
      check_val("t3_latency", n, 7);
      check_val("t3_word0", ks_data, 8'h01);
      next_word(n);
      check_val("t3_word1", ks_data, 8'h1C);

      // enable toggling every cycle, starting low
      do_reset();
      ph = 0;
      n  = 0;
      do begin
         enable = ph[0];
         step();
         ph++;
         n++;
      end while (!ks_valid && n < 100);
      check_val("t5_latency", n, 16);
      check_val("t5_word0", ks_data, 8'h01);
      n = 0;
      do begin
         enable = ph[0];
         step();
         ph++;
         n++;
      end while (!ks_valid && n < 100);
      check_val("t5_gap", n, 16);
      check_val("t5_word1", ks_data, 8'h1C);

      // seed_load on the same edge as a handshake
      enable    = 1'b1;
      seed_load = 1'b1;
      seed      = 8'h3C;
      step();
      seed_load = 1'b0;
      check_val("t5_load_valid", ks_valid, 0);
      check_val("t5_load_seed_zero", seed_zero, 0);
      next_word(n);
      check_val("t5_load_latency", n, 8);
      check_val("t5_load_word", ks_data, 8'h3C);

      // Full period of the maximal-length sequence
      do_reset();
      for (int k = 0; k < 256; k++) begin
         next_word(n);
         words[k] = ks_data;
      end
      check_val("t6_word0", words[0], 8'h01);
      check_val("t6_word1", words[1], 8'h1C);
      check_val("t6_word2", words[2], 8'h4B);
      rep = 0;
      for (int k = 1; k < 255; k++) if (words[k] == words[0]) rep++;
      check_val("t6_early_repeat", rep, 0);
      check_val("t6_period", words[255], words[0]);

      // Reset mid-fill overrides a simultaneous zero-seed load
      step(); step(); step(); step();
      reset     = 1'b1;
      seed_load = 1'b1;
      seed      = 8'h00;
      step();
      reset     = 1'b0;
      seed_load = 1'b0;
      check_val("t6_rst_valid", ks_valid, 0);
      check_val("t6_rst_data", ks_data, 0);
      check_val("t6_rst_seed_zero", seed_zero, 0);
      check_val("t6_rst_busy", busy, 1);
      next_word(n);
      check_val("t6_rst_latency", n, 8);
      check_val("t6_rst_word0", ks_data, 8'h01);
      next_word(n);
      check_val("t6_rst_word1", ks_data, 8'h1C);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
